// File: rtl/rv_multicycle_ctrl.sv
// Control FSM for the multicycle RV32I core: sequences fetch/decode/execute/memory/writeback,
// owns the unified memory handshake, the bus-timeout watchdog and the retired-instruction counter.
module rv_multicycle_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    input  logic             branch_taken,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             ir_we,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic [2:0]       imm_sel,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             illegal,
    output logic             bus_err,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        ALU_WB   = 4'd4,
        MEM_ADDR = 4'd5,
        MEM_RD   = 4'd6,
        LOAD_WB  = 4'd7,
        MEM_WR   = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        JALR     = 4'd11,
        LUI      = 4'd12,
        AUIPC    = 4'd13,
        TRAP     = 4'd15
    } state_e;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    // The counter holds the number of idle cycles already spent; the trap fires on the
    // cycle that would make it reach TIMEOUT_CYCLES.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e             state_q, state_d;
    logic [15:0]        wait_q, wait_d;
    logic               illegal_q, illegal_d;
    logic               bus_err_q, bus_err_d;
    logic               is_store_q, is_store_d;
    logic [CNT_W-1:0]   instret_q, instret_d;
    logic               wait_state;

    assign wait_state = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);

    always_comb begin
        state_d    = state_q;
        illegal_d  = illegal_q;
        bus_err_d  = bus_err_q;
        is_store_d = is_store_q;
        wait_d     = wait_q;
        instret_d  = instret_q;

        case (state_q)
            FETCH, MEM_RD, MEM_WR: begin
                if (mem_ready) begin
                    case (state_q)
                        FETCH:   state_d = DECODE;
                        MEM_RD:  state_d = LOAD_WB;
                        default: state_d = FETCH;
                    endcase
                end else if (wait_q == WAIT_LAST) begin
                    state_d   = TRAP;
                    bus_err_d = 1'b1;
                end
            end
            DECODE: begin
                is_store_d = (opcode == OP_STORE);
                case (opcode)
                    OP_R:              state_d = EXEC_R;
                    OP_I:              state_d = EXEC_I;
                    OP_LOAD, OP_STORE: state_d = MEM_ADDR;
                    OP_BR:             state_d = BRANCH;
                    OP_JAL:            state_d = JAL;
                    OP_JALR:           state_d = JALR;
                    OP_LUI:            state_d = LUI;
                    OP_AUIPC:          state_d = AUIPC;
                    default: begin
                        state_d   = TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            EXEC_R, EXEC_I, AUIPC:          state_d = ALU_WB;
            MEM_ADDR:                       state_d = is_store_q ? MEM_WR : MEM_RD;
            ALU_WB, LOAD_WB, BRANCH,
            JAL, JALR, LUI:                 state_d = FETCH;
            TRAP:                           state_d = TRAP;
            default:                        state_d = TRAP;
        endcase

        // Any state change re-arms the watchdog; staying in a wait state means no mem_ready.
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (wait_state) begin
            wait_d = wait_q + 16'd1;
        end

        if (state_d == FETCH && state_q != FETCH && state_q != TRAP) begin
            instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            wait_q     <= '0;
            illegal_q  <= 1'b0;
            bus_err_q  <= 1'b0;
            is_store_q <= 1'b0;
            instret_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            illegal_q  <= illegal_d;
            bus_err_q  <= bus_err_d;
            is_store_q <= is_store_d;
            instret_q  <= instret_d;
        end
    end

    // Moore decode of the datapath controls; only FETCH and BRANCH look at inputs.
    always_comb begin
        pc_we     = 1'b0;
        pc_src    = 2'd0;
        ir_we     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        iord      = 1'b0;
        imm_sel   = 3'd0;
        alu_src_a = 1'b0;
        alu_src_b = 2'd0;
        alu_op    = 2'd0;
        reg_we    = 1'b0;
        wb_sel    = 2'd0;
        if (rst_n) begin
            case (state_q)
                FETCH: begin
                    mem_req   = 1'b1;
                    ir_we     = mem_ready;
                    pc_we     = mem_ready;
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd2;
                end
                EXEC_R: alu_op = 2'd2;
                EXEC_I: begin
                    alu_op    = 2'd2;
                    alu_src_b = 2'd1;
                end
                AUIPC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd1;
                    imm_sel   = 3'd3;
                end
                ALU_WB: reg_we = 1'b1;
                MEM_ADDR: begin
                    alu_src_b = 2'd1;
                    imm_sel   = is_store_q ? 3'd1 : 3'd0;
                end
                MEM_RD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                LOAD_WB: begin
                    reg_we = 1'b1;
                    wb_sel = 2'd1;
                end
                MEM_WR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    iord    = 1'b1;
                end
                BRANCH: begin
                    imm_sel = 3'd2;
                    alu_op  = 2'd1;
                    pc_we   = branch_taken;
                    pc_src  = 2'd1;
                end
                JAL: begin
                    imm_sel = 3'd4;
                    pc_we   = 1'b1;
                    pc_src  = 2'd1;
                    reg_we  = 1'b1;
                    wb_sel  = 2'd2;
                end
                JALR: begin
                    alu_src_b = 2'd1;
                    pc_we     = 1'b1;
                    pc_src    = 2'd2;
                    reg_we    = 1'b1;
                    wb_sel    = 2'd2;
                end
                LUI: begin
                    imm_sel = 3'd3;
                    reg_we  = 1'b1;
                    wb_sel  = 2'd3;
                end
                default: ;
            endcase
        end
    end

    assign illegal = illegal_q;
    assign bus_err = bus_err_q;
    assign state   = state_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Directed bench for rv_multicycle_ctrl: walks each instruction class through the FSM and
// compares state and the full control vector against hand-derived expectations.
module tb_rv_multicycle_ctrl;

    logic        clk;
    logic        rst_n;
    logic [6:0]  opcode;
    logic        mem_ready;
    logic        branch_taken;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic        ir_we;
    logic        mem_req;
    logic        mem_we;
    logic        iord;
    logic [2:0]  imm_sel;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic        illegal;
    logic        bus_err;
    logic [3:0]  state;
    logic [31:0] instret;
    logic [17:0] ctrl;

    int n_checks = 0;
    int n_fail   = 0;

    rv_multicycle_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .imm_sel(imm_sel),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_we(reg_we),
        .wb_sel(wb_sel), .illegal(illegal), .bus_err(bus_err), .state(state), .instret(instret)
    );

    assign ctrl = {pc_we, pc_src, ir_we, mem_req, mem_we, iord, imm_sel,
                   alu_src_a, alu_src_b, alu_op, reg_we, wb_sel};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [17:0] cv(input logic pcw, input logic [1:0] pcs, input logic irw,
                                       input logic req, input logic we, input logic io,
                                       input logic [2:0] imm, input logic sa, input logic [1:0] sb,
                                       input logic [1:0] op, input logic rw, input logic [1:0] wb);
        return {pcw, pcs, irw, req, we, io, imm, sa, sb, op, rw, wb};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check state and control vector for the current cycle, then advance one clock.
    task automatic step_chk(input string tag, input logic [3:0] st, input logic [17:0] c);
        #1;
        check({tag, "_state"}, 32'(state), 32'(st));
        check({tag, "_ctrl"}, 32'(ctrl), 32'(c));
        tick();
    endtask

    task automatic do_fetch(input logic [6:0] op, input int waits);
        opcode    = op;
        mem_ready = 1'b0;
        for (int i = 0; i < waits; i++)
            step_chk("fetch_wait", 4'd0, cv(0, 0, 0, 1, 0, 0, 0, 1, 2, 0, 0, 0));
        mem_ready = 1'b1;
        step_chk("fetch_ready", 4'd0, cv(1, 0, 1, 1, 0, 0, 0, 1, 2, 0, 0, 0));
        mem_ready = 1'b0;
        step_chk("decode", 4'd1, '0);
    endtask

    initial begin
        rst_n = 1'b0; opcode = 7'd0; mem_ready = 1'b0; branch_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_ctrl", 32'(ctrl), 32'd0);
        check("rst_instret", instret, 32'd0);
        check("rst_flags", {30'd0, illegal, bus_err}, 32'd0);

        rst_n = 1'b1;
        step_chk("fetch_wait", 4'd0, cv(0, 0, 0, 1, 0, 0, 0, 1, 2, 0, 0, 0));
        rst_n = 1'b0;
        repeat (3) tick();
        check("midrst_state", 32'(state), 32'd0);
        check("midrst_mem_req", 32'(mem_req), 32'd0);
        check("midrst_ctrl", 32'(ctrl), 32'd0);
        check("midrst_instret", instret, 32'd0);
        rst_n = 1'b1;
        #1;
        check("rel_mem_req", 32'(mem_req), 32'd1);

        // ADDI, zero-wait fetch
        do_fetch(7'b0010011, 0);
        step_chk("exec_i", 4'd3, cv(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0));
        step_chk("alu_wb", 4'd4, cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        check("addi_instret", instret, 32'd1);

        // LW with two idle cycles in MEM_RD
        do_fetch(7'b0000011, 0);
        step_chk("mem_addr_ld", 4'd5, cv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        step_chk("mem_rd_w0", 4'd6, cv(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        step_chk("mem_rd_w1", 4'd6, cv(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        mem_ready = 1'b1;
        step_chk("mem_rd_done", 4'd6, cv(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        mem_ready = 1'b0;
        step_chk("load_wb", 4'd7, cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        check("lw_instret", instret, 32'd2);

        // SW, zero-wait write
        do_fetch(7'b0100011, 0);
        step_chk("mem_addr_st", 4'd5, cv(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
        mem_ready = 1'b1;
        step_chk("mem_wr", 4'd8, cv(0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0));
        mem_ready = 1'b0;
        #1;
        check("sw_back_fetch", 32'(state), 32'd0);
        check("sw_mem_we_low", 32'(mem_we), 32'd0);
        check("sw_instret", instret, 32'd3);

        // BEQ taken, then not taken
        do_fetch(7'b1100011, 0);
        branch_taken = 1'b1;
        step_chk("branch_taken", 4'd9, cv(1, 1, 0, 0, 0, 0, 2, 0, 0, 1, 0, 0));
        branch_taken = 1'b0;
        do_fetch(7'b1100011, 0);
        step_chk("branch_not", 4'd9, cv(0, 1, 0, 0, 0, 0, 2, 0, 0, 1, 0, 0));
        check("beq_instret", instret, 32'd5);

        // R-type after a 3-cycle fetch stall: watchdog must have been re-armed
        do_fetch(7'b0110011, 3);
        step_chk("exec_r", 4'd2, cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0));
        step_chk("alu_wb_r", 4'd4, cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));

        do_fetch(7'b0010111, 1);
        step_chk("auipc", 4'd13, cv(0, 0, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0));
        step_chk("alu_wb_auipc", 4'd4, cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));

        do_fetch(7'b1101111, 0);
        step_chk("jal", 4'd10, cv(1, 1, 0, 0, 0, 0, 4, 0, 0, 0, 1, 2));
        do_fetch(7'b1100111, 0);
        step_chk("jalr", 4'd11, cv(1, 2, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2));
        do_fetch(7'b0110111, 0);
        step_chk("lui", 4'd12, cv(0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 1, 3));
        check("mix_instret", instret, 32'd10);

        // Illegal opcode traps and stays
        do_fetch(7'b1111111, 0);
        check("ill_flag", 32'(illegal), 32'd1);
        step_chk("trap_ill0", 4'd15, '0);
        step_chk("trap_ill1", 4'd15, '0);
        check("ill_bus_err", 32'(bus_err), 32'd0);
        check("ill_instret", instret, 32'd10);
        rst_n = 1'b0;
        tick();
        check("ill_cleared", 32'(illegal), 32'd0);

        // Fetch timeout with TIMEOUT_CYCLES=4
        rst_n = 1'b1;
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            step_chk("to_wait", 4'd0, cv(0, 0, 0, 1, 0, 0, 0, 1, 2, 0, 0, 0));
        step_chk("to_trap", 4'd15, '0);
        check("to_bus_err", 32'(bus_err), 32'd1);
        check("to_illegal", 32'(illegal), 32'd0);
        check("to_instret", instret, 32'd0);
        rst_n = 1'b0;
        tick();
        check("to_rst_bus_err", 32'(bus_err), 32'd0);
        check("to_rst_state", 32'(state), 32'd0);
        rst_n = 1'b1;
        #1;
        check("to_rel_mem_req", 32'(mem_req), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
